pattern_detect_fsm: RTL and testbench
=====================================

# pattern_detect_fsm

Parametrised serial pattern-detector state machine, successor to the single-bit Moore FSM exercises. It samples one serial input bit per enabled clock and compares the last W bits against a compile-time pattern. It selects overlapping or non-overlapping match semantics and keeps a saturating hit counter. It is used standalone as an exercise top or as the detection stage in front of the team's serial-protocol blocks.

## Interface
- W, 4, pattern length in bits (W >= 2)
- PATTERN, 4'b1101, W-bit target; PATTERN[W-1] is the oldest bit, PATTERN[0] the newest
- OVERLAP, 1, 1 = a match's tail bits may start the next match; 0 = detection restarts from empty after each match
- CW, 8, width of hit counter (CW >= 1)

- clk  input  1  single clock, all state updates on rising edge
- resetn  input  1  synchronous reset, active-low
- en  input  1  sample enable; `in` is consumed only on edges where en=1
- in  input  1  serial data bit
- out  output  1  registered Moore match flag, one cycle per match
- hits  output  CW  saturating count of matches since reset

## Operation
- State: shift register sr[W-1:0] (newest bit at sr[0]) and fill counter fill, range 0..W, width $clog2(W+1).
- fill is the FSM state:
  - EMPTY = 0.
  - PARTIAL(k) = 1..W-1.
  - FULL = W.
- Reset (resetn=0 at an edge): sr=0, fill=0, out=0, hits=0. Reset dominates en and in.
- Edge with en=1:
  - sr_n = {sr[W-2:0], in}; fill_n = min(fill+1, W).
  - match = (fill_n == W) && (sr_n == PATTERN).
  - out <= match.
  - hits <= hits+1 if match and hits != 2^CW-1, otherwise holds.
  - fill <= (match && !OVERLAP) ? 0 : fill_n; sr <= sr_n in both modes.
- Edge with en=0: sr, fill and hits hold; out <= 0.
- Transitions:
  - EMPTY -> PARTIAL(1) -> … -> FULL on successive enabled bits.
  - FULL stays FULL.
  - With OVERLAP=0, a match returns the FSM to EMPTY.
- Fill guard: no match is reported until W bits have been sampled since reset, or since the last non-overlap match. This applies even if the reset value of sr equals PATTERN (e.g. all zeros).
- Saturation: hits stops at 2^CW-1, wraps never. out still pulses on every match.

## Timing
- Latency: out rises immediately after the edge that samples the completing bit. It is high for exactly one cycle unless the next enabled edge also matches.
- Back-to-back matches (OVERLAP=1, e.g. PATTERN all ones with in held 1) hold out high continuously. hits increments every cycle.
- hits updates on the same edge as out.
- Reset asserted mid-pattern: all state clears at that edge. The partial history is discarded, so a pattern completed by bits straddling the reset never matches.
- Deasserting resetn: the first edge with resetn=1 and en=1 samples `in` as bit 1.
- en toggling mid-pattern: the partial state is preserved across disabled cycles, and `in` is ignored while en=0.
- No combinational path from inputs to outputs.

## Test plan
1. Reset: hold resetn=0 two cycles while driving en=1, in=1 -> out=0, hits=0, fill=0. Then feed 1,1,0 and assert resetn=0 for one edge, followed by 1 -> no match; hits=0.
2. Basic match (W=4, PATTERN=1101, OVERLAP=1): with en=1 feed 1,1,0,1 -> out=1 for one cycle after the 4th edge; hits=1; out=0 on the next cycle (input 0).
3. Overlap mode: feed 1,1,0,1,1,0,1 -> with OVERLAP=1, out pulses after bits 4 and 7 and hits=2. With OVERLAP=0 the same stream pulses only after bit 4 and hits=1.
4. Enable gaps: feed 1,1, then three cycles with en=0 and in=0, then 0,1 with en=1 -> a single pulse after the last bit; out=0 throughout the en=0 cycles; hits=1.
5. Fill guard (PATTERN=4'b0000): after reset feed 0,0,0 -> no pulse. A 4th 0 -> pulse; further zeros with OVERLAP=1 -> out stays high and hits increments every cycle.
6. Saturation (CW=2, PATTERN=4'b1111, OVERLAP=1): hold in=1 for 8 enabled cycles -> hits reads 1,2,3,3,3 from the 4th edge onward, and out stays high from the 4th edge.

Source files
------------

// File: rtl/pattern_detect_fsm.sv
// pattern_detect_fsm
//
// Serial pattern detector. One bit of `in` is shifted in on every rising edge
// with en=1, and the last W bits are compared against PATTERN (PATTERN[W-1] is
// the oldest bit). A fill counter is the FSM state: 0 = empty, 1..W-1 = partial,
// W = full. No match is reported until the window holds W freshly sampled bits.
// With OVERLAP=0 a match sends the FSM back to empty.
//
// Parameters:
//   W       - pattern length in bits (>= 2)
//   PATTERN - W-bit target sequence
//   OVERLAP - 1: a match's tail may start the next match; 0: restart after match
//   CW      - hit counter width (>= 1)
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   resetn - synchronous active-low reset, dominates en/in
//   en     - sample enable
//   in     - serial data bit
//   out    - registered match flag, high for the cycle after each match
//   hits   - saturating count of matches since reset

module pattern_detect_fsm #(
  parameter int unsigned    W       = 4,
  parameter logic [W-1:0]   PATTERN = 4'b1101,
  parameter bit             OVERLAP = 1'b1,
  parameter int unsigned    CW      = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          in,
  output logic          out,
  output logic [CW-1:0] hits
);

  localparam int unsigned FW = $clog2(W + 1);
  localparam logic [FW-1:0] FillFull = FW'(W);
  localparam logic [CW-1:0] HitsMax  = {CW{1'b1}};

  logic [W-1:0]  r_sr;
  logic [FW-1:0] r_fill;
  logic          r_out;
  logic [CW-1:0] r_hits;

  logic [W-1:0]  w_sr_n;
  logic [FW-1:0] w_fill_n;
  logic          w_match;

  always_comb begin
    w_sr_n   = {r_sr[W-2:0], in};
    w_fill_n = (r_fill == FillFull) ? r_fill : r_fill + 1'b1;
    // The fill check keeps a reset-valued or stale window from matching.
    w_match  = (w_fill_n == FillFull) && (w_sr_n == PATTERN);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sr   <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
      r_hits <= '0;
    end else if (en) begin
      r_sr  <= w_sr_n;
      r_out <= w_match;
      if (w_match && !OVERLAP) begin
        r_fill <= '0;
      end else begin
        r_fill <= w_fill_n;
      end
      if (w_match && (r_hits != HitsMax)) begin
        r_hits <= r_hits + 1'b1;
      end
    end else begin
      // Disabled edges keep history and count; the flag is a one-cycle pulse.
      r_out <= 1'b0;
    end
  end

  assign out  = r_out;
  assign hits = r_hits;

endmodule

// File: tb/tb_pattern_detect_fsm.sv
module tb_pattern_detect_fsm;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b0;
  logic in = 1'b0;

  logic       out_a, out_b, out_c, out_d;
  logic [7:0] hits_a, hits_b, hits_c;
  logic [1:0] hits_d;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // A: 1101 overlap, B: 1101 non-overlap, C: 0000 overlap, D: 1111 overlap CW=2
  pattern_detect_fsm #(.W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CW(8)) u_a (
    .clk(clk), .resetn(resetn), .en(en), .in(in), .out(out_a), .hits(hits_a));
  pattern_detect_fsm #(.W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CW(8)) u_b (
    .clk(clk), .resetn(resetn), .en(en), .in(in), .out(out_b), .hits(hits_b));
  pattern_detect_fsm #(.W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .CW(8)) u_c (
    .clk(clk), .resetn(resetn), .en(en), .in(in), .out(out_c), .hits(hits_c));
  pattern_detect_fsm #(.W(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CW(2)) u_d (
    .clk(clk), .resetn(resetn), .en(en), .in(in), .out(out_d), .hits(hits_d));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, return 1 time unit after the rising edge.
  task automatic tick(input logic r, input logic e, input logic d);
    @(negedge clk);
    resetn = r;
    en     = e;
    in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    bit [6:0] stream;
    bit [6:0] exp_a;
    bit [6:0] exp_b;

    // 1. Reset, then reset in the middle of a pattern
    do_reset();
    check("rst_out_a", out_a, 0);
    check("rst_hits_a", hits_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_hits_b", hits_b, 0);
    check("rst_out_c", out_c, 0);
    check("rst_hits_c", hits_c, 0);
    check("rst_out_d", out_d, 0);
    check("rst_hits_d", hits_d, 0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    check("pre_midrst_out_a", out_a, 0);
    tick(1'b0, 1'b1, 1'b1);
    check("midrst_out_a", out_a, 0);
    tick(1'b1, 1'b1, 1'b1);
    check("post_midrst_out_a", out_a, 0);
    check("post_midrst_hits_a", hits_a, 0);
    check("post_midrst_out_b", out_b, 0);

    // 2. Basic match 1101, then an idle-enabled 0, then a disabled cycle
    do_reset();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    check("basic_b3_out_a", out_a, 0);
    tick(1'b1, 1'b1, 1'b1);
    check("basic_out_a", out_a, 1);
    check("basic_hits_a", hits_a, 1);
    check("basic_out_b", out_b, 1);
    check("basic_hits_b", hits_b, 1);
    check("basic_out_c", out_c, 0);
    tick(1'b1, 1'b1, 1'b0);
    check("basic_next_out_a", out_a, 0);
    check("basic_next_hits_a", hits_a, 1);

    // 3. Overlap vs non-overlap on 1101101
    do_reset();
    stream = 7'b1101101;
    exp_a  = 7'b0001001;
    exp_b  = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      tick(1'b1, 1'b1, stream[i]);
      check($sformatf("ovl_out_a_bit%0d", 7 - i), out_a, exp_a[i]);
      check($sformatf("ovl_out_b_bit%0d", 7 - i), out_b, exp_b[i]);
    end
    check("ovl_hits_a", hits_a, 2);
    check("ovl_hits_b", hits_b, 1);

    // 4. Enable gaps mid-pattern
    do_reset();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      check($sformatf("gap_dis%0d_out_a", i), out_a, 0);
    end
    tick(1'b1, 1'b1, 1'b0);
    check("gap_b3_out_a", out_a, 0);
    tick(1'b1, 1'b1, 1'b1);
    check("gap_out_a", out_a, 1);
    check("gap_hits_a", hits_a, 1);
    tick(1'b1, 1'b0, 1'b1);
    check("gap_after_dis_out_a", out_a, 0);
    check("gap_after_dis_hits_a", hits_a, 1);

    // 5. Fill guard with all-zero pattern
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      check($sformatf("guard_bit%0d_out_c", i), out_c, 0);
    end
    check("guard_hits_c_pre", hits_c, 0);
    for (int i = 4; i <= 6; i++) begin
      tick(1'b1, 1'b1, 1'b0);
      check($sformatf("guard_bit%0d_out_c", i), out_c, 1);
      check($sformatf("guard_bit%0d_hits_c", i), hits_c, i - 3);
    end

    // 6. Saturation with CW=2, all-ones pattern
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b1, 1'b1);
      check($sformatf("sat_edge%0d_out_d", k), out_d, (k >= 4) ? 1 : 0);
      check($sformatf("sat_edge%0d_hits_d", k), hits_d,
            (k < 4) ? 0 : ((k - 3 > 3) ? 3 : k - 3));
    end
    check("sat_out_a", out_a, 0);
    tick(1'b0, 1'b1, 1'b1);
    check("sat_rst_out_d", out_d, 0);
    check("sat_rst_hits_d", hits_d, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
